// File: rtl/qosc_sequencer.sv
// Sequencer for a quadrature oscillator: register file, burst run control and collapse watchdog.
// All outputs registered; start ignored while busy or with stop held, stop aborts LOAD/RUN next cycle.
module qosc_sequencer #(
    parameter int MAX_RESTART = 3,
    parameter int AMP_MIN     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [7:0]        cfg_wdata,
    input  logic              start,
    input  logic              stop,
    input  logic signed [7:0] accu_re,
    input  logic signed [7:0] accu_im,
    output logic              osc_load,
    output logic              osc_run,
    output logic [7:0]        re_coeff,
    output logic [7:0]        im_coeff,
    output logic [7:0]        power,
    output logic [7:0]        accu_re_init,
    output logic [7:0]        accu_im_init,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [3:0]        restart_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FAULT} state_t;

    typedef struct packed {
        logic [7:0]  re_coeff;
        logic [7:0]  im_coeff;
        logic [7:0]  power;
        logic [7:0]  re_init;
        logic [7:0]  im_init;
        logic [15:0] burst;
        logic [7:0]  wd_window;
    } cfg_t;

    localparam logic [8:0] AMP_MIN_W = 9'(AMP_MIN);

    logic [7:0]  regs_q [0:7];
    cfg_t        regs_cfg;
    cfg_t        cfg_q, cfg_d;
    state_t      state_q, state_d;
    logic [15:0] burst_cnt_q, burst_cnt_d;
    logic [7:0]  col_cnt_q, col_cnt_d, col_next;
    logic [3:0]  rst_cnt_q, rst_cnt_d;
    logic        done_d;
    logic        osc_load_q, osc_run_q, busy_q, done_q, fault_q;
    logic        collapse;

    // Widen before negating so that -128 maps to +128 rather than wrapping.
    function automatic logic [8:0] abs9(input logic [7:0] v);
        logic [8:0] ext;
        ext = {v[7], v};
        return v[7] ? (9'd0 - ext) : ext;
    endfunction

    assign collapse = (abs9(accu_re) < AMP_MIN_W) && (abs9(accu_im) < AMP_MIN_W);

    always_comb begin
        regs_cfg.re_coeff  = regs_q[0];
        regs_cfg.im_coeff  = regs_q[1];
        regs_cfg.power     = regs_q[2];
        regs_cfg.re_init   = regs_q[3];
        regs_cfg.im_init   = regs_q[4];
        regs_cfg.burst     = {regs_q[6], regs_q[5]};
        regs_cfg.wd_window = regs_q[7];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= 8'd0;
        end else if (cfg_we) begin
            regs_q[cfg_addr] <= cfg_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        burst_cnt_d = burst_cnt_q;
        col_cnt_d   = col_cnt_q;
        rst_cnt_d   = rst_cnt_q;
        done_d      = 1'b0;
        col_next    = 8'd0;
        case (state_q)
            S_IDLE, S_FAULT: begin
                if (start && !stop) begin
                    state_d     = S_LOAD;
                    cfg_d       = regs_cfg;
                    burst_cnt_d = regs_cfg.burst;
                    rst_cnt_d   = 4'd0;
                end
            end
            S_LOAD: begin
                col_cnt_d = 8'd0;
                state_d   = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (collapse) col_next = (col_cnt_q == 8'hFF) ? 8'hFF : col_cnt_q + 8'd1;
                col_cnt_d = col_next;
                if (cfg_q.burst != 16'd0) burst_cnt_d = burst_cnt_q - 16'd1;
                // stop outranks burst expiry, which outranks the watchdog
                if (stop) begin
                    state_d = S_IDLE;
                end else if (cfg_q.burst != 16'd0 && burst_cnt_q == 16'd1) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (cfg_q.wd_window != 8'd0 && col_next == cfg_q.wd_window) begin
                    if (int'(rst_cnt_q) < MAX_RESTART) begin
                        state_d   = S_LOAD;
                        rst_cnt_d = (rst_cnt_q == 4'hF) ? 4'hF : rst_cnt_q + 4'd1;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cfg_q       <= '0;
            burst_cnt_q <= 16'd0;
            col_cnt_q   <= 8'd0;
            rst_cnt_q   <= 4'd0;
            osc_load_q  <= 1'b0;
            osc_run_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            burst_cnt_q <= burst_cnt_d;
            col_cnt_q   <= col_cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            osc_load_q  <= (state_d == S_LOAD);
            osc_run_q   <= (state_d == S_RUN);
            busy_q      <= (state_d == S_LOAD) || (state_d == S_RUN);
            done_q      <= done_d;
            fault_q     <= (state_d == S_FAULT);
        end
    end

    assign osc_load     = osc_load_q;
    assign osc_run      = osc_run_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign fault        = fault_q;
    assign restart_cnt  = rst_cnt_q;
    assign re_coeff     = cfg_q.re_coeff;
    assign im_coeff     = cfg_q.im_coeff;
    assign power        = cfg_q.power;
    assign accu_re_init = cfg_q.re_init;
    assign accu_im_init = cfg_q.im_init;

endmodule

// File: tb/tb_qosc_sequencer.sv
// Bench for qosc_sequencer: directed scenarios, a per-cycle reference model and literal spot checks.
module tb_qosc_sequencer;

    localparam int MAX_R = 3;
    localparam int AMP   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [2:0]        cfg_addr = 3'd0;
    logic [7:0]        cfg_wdata = 8'd0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic signed [7:0] accu_re = 8'sd80;
    logic signed [7:0] accu_im = 8'sd80;
    logic              osc_load, osc_run, busy, done, fault;
    logic [7:0]        re_coeff, im_coeff, power, accu_re_init, accu_im_init;
    logic [3:0]        restart_cnt;

    int compared = 0;
    int mismatched = 0;
    bit cmp_en = 1'b0;

    qosc_sequencer #(.MAX_RESTART(MAX_R), .AMP_MIN(AMP)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .start(start), .stop(stop), .accu_re(accu_re), .accu_im(accu_im),
        .osc_load(osc_load), .osc_run(osc_run), .re_coeff(re_coeff), .im_coeff(im_coeff),
        .power(power), .accu_re_init(accu_re_init), .accu_im_init(accu_im_init),
        .busy(busy), .done(done), .fault(fault), .restart_cnt(restart_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 load, 2 run, 3 fault; runs on the same edge as the DUT.
    logic [7:0] m_regs [8];
    logic [7:0] m_act  [8];
    int m_mode = 0, m_left = 0, m_streak = 0, m_restarts = 0;
    bit m_done = 1'b0;

    function automatic int iabs(input logic signed [7:0] v);
        int x;
        x = int'(v);
        return (x < 0) ? -x : x;
    endfunction

    always @(posedge clk) begin
        int burst, wd;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin m_regs[i] = 8'd0; m_act[i] = 8'd0; end
            m_mode = 0; m_left = 0; m_streak = 0; m_restarts = 0; m_done = 1'b0;
        end else begin
            burst  = {m_act[6], m_act[5]};
            wd     = m_act[7];
            m_done = 1'b0;
            if (m_mode == 0 || m_mode == 3) begin
                if (start && !stop) begin
                    for (int i = 0; i < 8; i++) m_act[i] = m_regs[i];
                    m_left = {m_regs[6], m_regs[5]};
                    m_restarts = 0;
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                m_streak = 0;
                m_mode = stop ? 0 : 2;
            end else begin
                if (iabs(accu_re) < AMP && iabs(accu_im) < AMP)
                    m_streak = (m_streak < 255) ? m_streak + 1 : 255;
                else
                    m_streak = 0;
                if (burst != 0) m_left = m_left - 1;
                if (stop) m_mode = 0;
                else if (burst != 0 && m_left == 0) begin m_mode = 0; m_done = 1'b1; end
                else if (wd != 0 && m_streak == wd) begin
                    if (m_restarts < MAX_R) begin
                        m_restarts = (m_restarts < 15) ? m_restarts + 1 : 15;
                        m_mode = 1;
                    end else m_mode = 3;
                end
            end
            if (cfg_we) m_regs[cfg_addr] = cfg_wdata;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cycle_outputs",
                64'({osc_load, osc_run, busy, fault, done, restart_cnt,
                     re_coeff, im_coeff, power, accu_re_init, accu_im_init}),
                64'({m_mode == 1, m_mode == 2, (m_mode == 1 || m_mode == 2), m_mode == 3,
                     m_done, 4'(m_restarts), m_act[0], m_act[1], m_act[2], m_act[3], m_act[4]}));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] init_vals [8];
        int runs, done_at;
        init_vals = '{8'h7d, 8'h1b, 8'h10, 8'h20, 8'h00, 8'h05, 8'h00, 8'h00};

        tick(1);
        cmp_en = 1'b1;
        tick(1);
        chk("reset_outputs", 64'({osc_load, osc_run, busy, done, fault, restart_cnt, re_coeff}), 64'd0);
        rst = 1'b0;

        // Basic 5-cycle burst
        for (int i = 0; i < 8; i++) wr(3'(i), init_vals[i]);
        pulse_start();
        chk("load_strobe", 64'({osc_load, osc_run, busy}), 64'b101);
        chk("load_cfg", 64'({re_coeff, im_coeff, power, accu_re_init, accu_im_init}), 64'h7d1b102000);
        runs = 0; done_at = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (osc_run) runs++;
            if (done) begin done_at = i; break; end
        end
        chk("burst_run_cycles", 64'(runs), 64'd5);
        chk("done_cycle", 64'(done_at), 64'd5);
        chk("busy_at_done", 64'(busy), 64'd0);
        tick(1);
        chk("done_one_cycle", 64'(done), 64'd0);

        // Rewrite during a run only affects the next start
        pulse_start();
        tick(2);
        wr(3'd0, 8'h40);
        chk("active_copy_held", 64'(re_coeff), 64'h7d);
        tick(6);
        pulse_start();
        chk("new_copy_on_start", 64'(re_coeff), 64'h40);
        tick(7);

        // Free-run with stop
        wr(3'd5, 8'h00);
        pulse_start();
        tick(20);
        chk("free_running", 64'(osc_run), 64'd1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("stop_to_idle", 64'({osc_run, busy, done}), 64'd0);
        tick(1);
        chk("stop_no_done", 64'(done), 64'd0);

        // Watchdog restarts then fault
        wr(3'd7, 8'd3);
        accu_re = 8'sd0; accu_im = 8'sd0;
        pulse_start();
        for (int k = 1; k <= 3; k++) begin
            tick(4);
            chk("wd_restart_load", 64'(osc_load), 64'd1);
            chk("wd_restart_cnt", 64'(restart_cnt), 64'(k));
        end
        tick(4);
        chk("wd_fault", 64'({fault, osc_run, busy, restart_cnt}), 64'b1_0_0_0011);
        tick(3);
        chk("fault_sticky", 64'(fault), 64'd1);
        accu_re = 8'sd80; accu_im = 8'sd80;
        pulse_start();
        chk("fault_exit_load", 64'({osc_load, fault, restart_cnt}), 64'b1_0_0000);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("load_stop_idle", 64'(busy), 64'd0);

        // |-128| does not count as collapse; near-threshold values
        wr(3'd7, 8'd1);
        accu_re = -8'sd128; accu_im = 8'sd0;
        pulse_start();
        tick(10);
        chk("neg128_no_restart", 64'({osc_run, restart_cnt}), 64'b1_0000);
        accu_re = 8'sd2; tick(3);
        accu_re = -8'sd2; accu_im = 8'sd1; tick(3);
        chk("amp2_no_restart", 64'(restart_cnt), 64'd0);
        accu_re = -8'sd1; accu_im = 8'sd1;
        tick(1);
        chk("amp1_restart", 64'({osc_load, restart_cnt}), 64'b1_0001);
        accu_re = 8'sd80; accu_im = 8'sd80;
        stop = 1'b1; tick(1); stop = 1'b0;

        // Burst expiry beats watchdog in the same cycle
        wr(3'd5, 8'd3);
        wr(3'd7, 8'd3);
        accu_re = 8'sd0; accu_im = 8'sd0;
        pulse_start();
        tick(4);
        chk("expiry_over_wd", 64'({done, osc_load, restart_cnt}), 64'b1_0_0000);
        accu_re = 8'sd80; accu_im = 8'sd80;

        // Reset mid-run, with a write that must be ignored
        wr(3'd5, 8'd0);
        wr(3'd7, 8'd0);
        pulse_start();
        tick(5);
        rst = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 8'h99;
        tick(1);
        rst = 1'b0; cfg_we = 1'b0;
        chk("rst_midrun", 64'({osc_load, osc_run, busy, done, fault, restart_cnt, re_coeff}), 64'd0);
        tick(1);
        chk("rst_no_done", 64'(done), 64'd0);
        start = 1'b1; stop = 1'b1;
        tick(3);
        chk("start_stop_idle", 64'({busy, osc_load}), 64'd0);
        stop = 1'b0;
        tick(1);
        start = 1'b0;
        chk("regs_cleared", 64'({osc_load, re_coeff}), 64'h100);
        stop = 1'b1; tick(2); stop = 1'b0;
        tick(2);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/qosc_sequencer.md
QOSC_SEQUENCER -- requirements
Module: qosc_sequencer

Interface
REQ-001 Parameter MAX_RESTART, default 3, meaning: watchdog restarts allowed per run before fault.
REQ-002 Parameter AMP_MIN, default 2, meaning: collapse threshold on |accu_re| and |accu_im|.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 cfg_we  input  1  register write strobe.
REQ-006 cfg_addr  input  3  register address.
REQ-007 cfg_wdata  input  8  register write data.
REQ-008 start  input  1  begin run, level-sampled each cycle.
REQ-009 stop  input  1  abort run, level-sampled each cycle.
REQ-010 accu_re, accu_im  input  8 each  signed oscillator outputs.
REQ-011 osc_load  output  1  load strobe to oscillator.
REQ-012 osc_run  output  1  oscillator clock enable.
REQ-013 re_coeff, im_coeff, power, accu_re_init, accu_im_init  output  8 each  oscillator configuration.
REQ-014 busy  output  1  high in LOAD or RUN.
REQ-015 done  output  1  one-cycle pulse on normal burst completion.
REQ-016 fault  output  1  high in FAULT.
REQ-017 restart_cnt  output  4  watchdog restarts in current run.

Function
REQ-018 Register map: 0 re_coeff, 1 im_coeff, 2 power, 3 re_init, 4 im_init, 5 burst[7:0], 6 burst[15:8], 7 wd_window; addresses map to register file entries in this order.
REQ-019 Register file writes take effect on every edge with cfg_we=1, in any state.
REQ-020 Config outputs come from an active copy captured from the register file on entry to LOAD via start; writes during a run affect only the next start.
REQ-021 FSM states: IDLE, LOAD, RUN, FAULT.
REQ-022 IDLE: start=1 and stop=0 -> LOAD; clears restart_cnt; loads burst counter from burst.
REQ-023 LOAD: lasts exactly one cycle with osc_load=1 and osc_run=0; clears collapse counter; goes to RUN unless stop=1, in which case it goes to IDLE.
REQ-024 RUN: osc_run=1 and osc_load=0; when burst is non-zero, the burst counter decrements each RUN cycle.
REQ-025 Non-zero burst L yields exactly L RUN cycles summed across restarts, then IDLE with done=1 for the first IDLE cycle.
REQ-026 Burst 0 means free-run until stop or fault.
REQ-027 stop=1 in RUN -> IDLE next cycle, with no done pulse.
REQ-028 start is ignored while busy or while stop=1.
REQ-029 Collapse: in RUN, a cycle with |accu_re|<AMP_MIN and |accu_im|<AMP_MIN increments the collapse counter; any other RUN cycle clears it.
REQ-030 Absolute values use 9-bit arithmetic, so -128 yields 128.
REQ-031 When wd_window != 0 and the collapse counter reaches wd_window with restart_cnt<MAX_RESTART: -> LOAD with the same active copy, restart_cnt+1, burst counter unchanged.
REQ-032 When collapse reaches wd_window with restart_cnt==MAX_RESTART: -> FAULT.
REQ-033 wd_window=0 disables the watchdog.
REQ-034 FAULT: osc_run=0, osc_load=0, fault=1, busy=0.
REQ-035 FAULT exits only via rst, or via start=1 (with stop=0), which takes the IDLE start path of REQ-022.
REQ-036 Priority within RUN in one cycle: stop > burst expiry (done) > watchdog restart/fault.
REQ-037 restart_cnt saturates at 15.
REQ-038 The collapse counter is 8 bits.

Reset
REQ-039 rst=1 at an edge forces IDLE and zeroes all register-file entries, the active copy, all counters and all outputs, overriding every other input.
REQ-040 rst mid-run aborts the run with no done pulse; cfg_we during rst is ignored.

Verification
REQ-041 Write 0x7d,0x1b,0x10,0x20,0x00,0x05,0x00,0x00 to addr 0-7, pulse start -> osc_load 1 cycle with outputs 0x7d/0x1b/0x10/0x20/0x00, osc_run 5 cycles, done one cycle later, busy low.
REQ-042 burst=0, start, stop after 20 RUN cycles -> IDLE next cycle, no done, osc_run low.
REQ-043 wd_window=3, hold accu_re=accu_im=0 in RUN -> LOAD after 3 collapse cycles; restart_cnt 1,2,3 on successive restarts; fourth trigger -> fault=1, osc_run=0.
REQ-044 accu_re=-128, accu_im=0, wd_window=1 -> no restart (|-128|=128).
REQ-045 Rewrite re_coeff=0x40 mid-run -> re_coeff output stays 0x7d until the next start.
REQ-046 Assert rst mid-RUN -> next cycle all outputs 0, no done; start and stop asserted together in IDLE -> stays IDLE.
